// File: rtl/keypad_encoder_8to3_if.sv
// Event bus from the keypad encoder to the display path.
// The producer holds code/multi while valid is high until ready is seen.
interface keypad_encoder_8to3_if;
   logic [2:0] code;
   logic       valid;
   logic       ready;
   logic       multi;

   modport master (
      output code,
      output valid,
      output multi,
      input  ready
   );

   modport slave (
      input  code,
      input  valid,
      input  multi,
      output ready
   );
endinterface

// File: rtl/keypad_encoder_8to3.sv
// Eight raw push-buttons to a 3-bit press index: sync, debounce,
// rising-edge detect, priority encode, one-entry valid/ready register.
module keypad_encoder_8to3 #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [7:0]            btn,
   keypad_encoder_8to3_if.master evt,
   output logic                  overrun,
   output logic                  any_pressed
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [7:0]    s1;
   logic [7:0]    s2;
   logic [7:0]    s2_prev;
   logic [7:0]    stable;
   logic [7:0]    stable_prev;
   logic [7:0]    rise;
   logic [CW-1:0] cnt;
   logic [2:0]    enc;
   logic [2:0]    code;
   logic [2:0]    code_nx;
   logic          multi;
   logic          multi_nx;
   logic          multi_n;
   logic          overrun_nx;

   // One counter serves the whole vector: any bit change restarts it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1          <= '0;
         s2          <= '0;
         s2_prev     <= '0;
         cnt         <= '0;
         stable      <= '0;
         stable_prev <= '0;
         any_pressed <= 1'b0;
      end else begin
         s1          <= btn;
         s2          <= s1;
         s2_prev     <= s2;
         stable_prev <= stable;
         if (s2 != s2_prev) begin
            cnt <= '0;
         end else begin
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
               stable      <= s2;
               any_pressed <= |s2;
            end
         end
      end
   end

   always_comb begin
      rise    = stable & ~stable_prev;
      multi_n = $countones(stable) > 1;
      enc     = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (rise[i]) enc = 3'(i);
      end
   end

   always_comb begin
      state_nx   = state;
      code_nx    = code;
      multi_nx   = multi;
      overrun_nx = overrun;
      unique case (state)
         EMPTY: begin
            if (|rise) begin
               code_nx  = enc;
               multi_nx = multi_n;
               state_nx = FULL;
            end
         end
         FULL: begin
            if (evt.ready) begin
               overrun_nx = 1'b0;
               if (|rise) begin
                  code_nx  = enc;
                  multi_nx = multi_n;
               end else begin
                  state_nx = EMPTY;
               end
            end else if (|rise) begin
               overrun_nx = 1'b1;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= EMPTY;
         code    <= '0;
         multi   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nx;
         code    <= code_nx;
         multi   <= multi_nx;
         overrun <= overrun_nx;
      end
   end

   assign evt.code  = code;
   assign evt.multi = multi;
   assign evt.valid = (state == FULL);
endmodule
